// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned PC_STEP  = 4;
  localparam int unsigned RESET_PC = 0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue toward decode; each entry holds an instruction and its PC.
module fetch_queue #(
  parameter int unsigned QDEPTH = 2,
  parameter int unsigned XLEN   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [XLEN-1:0]          i_push_data,
  input  logic [XLEN-1:0]          i_push_pc,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [$clog2(QDEPTH):0]  o_count,
  output logic [XLEN-1:0]          o_head_data,
  output logic [XLEN-1:0]          o_head_pc
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] r_data [QDEPTH];
  logic [XLEN-1:0] r_pc   [QDEPTH];
  logic [PW-1:0]   r_rd;
  logic [PW-1:0]   r_wr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign w_push = i_push && (r_count != CW'(QDEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  // Pointers wrap naturally; flush overrides any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush && !rst) begin
      r_data[r_wr] <= i_push_data;
      r_pc[r_wr]   <= i_push_pc;
    end
  end

  assign o_count     = r_count;
  assign o_head_data = r_data[r_rd];
  assign o_head_pc   = r_pc[r_rd];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: single-outstanding imem requests, PC update, redirect flush.
// Optional macro FETCH_BYPASS_EN forwards a kept response straight to decode when the queue is empty.
module if_fetch_unit #(
  parameter int unsigned QDEPTH = 2,
  parameter int unsigned XLEN   = fetch_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] pc_next_o,
  output logic            pc_enable_o,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  import fetch_pkg::*;

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_req_pc;
  logic [CW-1:0]   w_count;
  logic [XLEN-1:0] w_head_data;
  logic [XLEN-1:0] w_head_pc;
  logic [XLEN-1:0] w_aligned_pc;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_keep;
  logic            w_bypass;
  logic            w_q_valid;
  logic            w_push;
  logic            w_pop;
  logic            w_flush;
  logic            w_hs;

  assign w_aligned_pc = pc_in & ~XLEN'(3);
  assign w_redir_pc   = redirect_pc & ~XLEN'(3);
  assign w_hs         = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_req_pc <= XLEN'(RESET_PC);
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) r_req_pc <= w_aligned_pc;
    end
  end

  // Redirect outranks everything; reset forces all outputs low.
  always_comb begin
    w_state_nxt    = r_state;
    pc_enable_o    = 1'b0;
    pc_next_o      = pc_in;
    imem_req_valid = 1'b0;
    imem_req_addr  = w_aligned_pc;
    w_keep         = 1'b0;
    if (rst) begin
      pc_next_o     = '0;
      imem_req_addr = '0;
      w_state_nxt   = IDLE;
    end else if (redirect_valid) begin
      pc_enable_o = 1'b1;
      pc_next_o   = w_redir_pc;
      case (r_state)
        WAIT, DROP: w_state_nxt = imem_rsp_valid ? IDLE : DROP;
        default:    w_state_nxt = IDLE;
      endcase
    end else begin
      case (r_state)
        IDLE: begin
          imem_req_valid = (w_count < CW'(QDEPTH));
          if (imem_req_valid && imem_req_ready) begin
            w_state_nxt = WAIT;
            pc_enable_o = 1'b1;
            pc_next_o   = pc_in + XLEN'(PC_STEP);
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            w_keep      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        DROP: begin
          if (imem_rsp_valid) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_keep && (w_count == '0);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_q_valid = (w_count != '0) && !rst;
  assign w_push    = w_keep && !(w_bypass && inst_ready);
  assign w_pop     = w_q_valid && inst_ready;
  assign w_flush   = redirect_valid && !rst;

  assign inst_valid = w_q_valid || w_bypass;
  assign inst_data  = w_q_valid ? w_head_data : (w_bypass ? imem_rsp_data : '0);
  assign inst_pc    = w_q_valid ? w_head_pc   : (w_bypass ? r_req_pc      : '0);

  fetch_queue #(
    .QDEPTH (QDEPTH),
    .XLEN   (XLEN)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (imem_rsp_data),
    .i_push_pc   (r_req_pc),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .o_count     (w_count),
    .o_head_data (w_head_data),
    .o_head_pc   (w_head_pc)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a PC-register model and a 1-cycle instruction memory.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] pc_next_o;
  logic        pc_enable_o;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  logic [31:0] pc_reg;
  logic        use_force;
  logic [31:0] pc_force;
  logic        mem_auto;
  logic        pend;
  logic [31:0] pend_addr;
  logic        man_rsp_valid;
  logic [31:0] man_rsp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.QDEPTH(2), .XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_next_o      (pc_next_o),
    .pc_enable_o    (pc_enable_o),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  // PC register and memory models; memory returns ~addr one cycle after accept.
  always @(posedge clk) begin
    if (rst) pc_reg <= 32'h0;
    else if (pc_enable_o) pc_reg <= pc_next_o;
    pend <= imem_req_valid && imem_req_ready;
    if (imem_req_valid && imem_req_ready) pend_addr <= imem_req_addr;
  end

  assign pc_in          = use_force ? pc_force : pc_reg;
  assign imem_rsp_valid = mem_auto ? pend : man_rsp_valid;
  assign imem_rsp_data  = mem_auto ? ~pend_addr : man_rsp_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    inst_ready = 1'b0; use_force = 1'b0; pc_force = 32'h0; mem_auto = 1'b1;
    man_rsp_valid = 1'b0; man_rsp_data = 32'h0;
    tick(); tick(); #1;
    chk("rst_pc_en", 32'(pc_enable_o), 32'h0);
    chk("rst_req_v", 32'(imem_req_valid), 32'h0);
    chk("rst_inst_v", 32'(inst_valid), 32'h0);
    chk("rst_pc_next", pc_next_o, 32'h0);

    // C0: first request from PC 0
    tick(); rst = 1'b0; #1;
    chk("c0_req_v", 32'(imem_req_valid), 32'h1);
    chk("c0_addr", imem_req_addr, 32'h0);
    chk("c0_pc_en", 32'(pc_enable_o), 32'h1);
    chk("c0_pc_next", pc_next_o, 32'h4);
    // C1: WAIT, response for 0
    tick(); #1;
    chk("c1_req_v", 32'(imem_req_valid), 32'h0);
    chk("c1_pc_en", 32'(pc_enable_o), 32'h0);
    chk("c1_inst_v", 32'(inst_valid), 32'h0);
    // C2: head is 0, next request 4
    tick(); #1;
    chk("c2_inst_v", 32'(inst_valid), 32'h1);
    chk("c2_inst_pc", inst_pc, 32'h0);
    chk("c2_inst_d", inst_data, 32'hFFFF_FFFF);
    chk("c2_addr", imem_req_addr, 32'h4);
    // C3: response for 4
    tick(); #1;
    // C4, C5: queue full, no request
    tick(); #1;
    chk("c4_full_req_v", 32'(imem_req_valid), 32'h0);
    chk("c4_inst_pc", inst_pc, 32'h0);
    tick(); #1;
    chk("c5_full_req_v", 32'(imem_req_valid), 32'h0);
    // C6: pop head 0
    tick(); inst_ready = 1'b1; #1;
    chk("c6_req_v", 32'(imem_req_valid), 32'h0);
    chk("c6_inst_pc", inst_pc, 32'h0);
    // C7: pop head 4, request 8
    tick(); #1;
    chk("c7_inst_pc", inst_pc, 32'h4);
    chk("c7_inst_d", inst_data, 32'hFFFF_FFFB);
    chk("c7_req_v", 32'(imem_req_valid), 32'h1);
    chk("c7_addr", imem_req_addr, 32'h8);
    // C8: response for 8, no bypass
    tick(); #1;
    chk("c8_inst_v", 32'(inst_valid), 32'h0);
    // C9: pop 8, request 0xC whose response is held back
    tick(); mem_auto = 1'b0; #1;
    chk("c9_inst_pc", inst_pc, 32'h8);
    chk("c9_inst_d", inst_data, 32'hFFFF_FFF7);
    chk("c9_addr", imem_req_addr, 32'hC);
    // C10: redirect while WAIT
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    chk("c10_pc_en", 32'(pc_enable_o), 32'h1);
    chk("c10_pc_next", pc_next_o, 32'h100);
    chk("c10_req_v", 32'(imem_req_valid), 32'h0);
    // C11: DROP, no request
    tick(); redirect_valid = 1'b0; #1;
    chk("c11_req_v", 32'(imem_req_valid), 32'h0);
    // C12: stale response arrives
    tick(); man_rsp_valid = 1'b1; man_rsp_data = 32'hDEAD_BEEF; #1;
    chk("c12_req_v", 32'(imem_req_valid), 32'h0);
    // C13: stale data discarded, request 0x100
    tick(); man_rsp_valid = 1'b0; mem_auto = 1'b1; #1;
    chk("c13_inst_v", 32'(inst_valid), 32'h0);
    chk("c13_addr", imem_req_addr, 32'h100);
    chk("c13_req_v", 32'(imem_req_valid), 32'h1);
    tick(); #1;
    // C15: first instruction after redirect
    tick(); #1;
    chk("c15_inst_v", 32'(inst_valid), 32'h1);
    chk("c15_inst_pc", inst_pc, 32'h100);
    chk("c15_inst_d", inst_data, 32'hFFFF_FEFF);
    chk("c15_addr", imem_req_addr, 32'h104);
    // C16: redirect coincides with response; unaligned target
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h102; #1;
    chk("c16_rsp_v", 32'(imem_rsp_valid), 32'h1);
    chk("c16_pc_next", pc_next_o, 32'h100);
    chk("c16_pc_en", 32'(pc_enable_o), 32'h1);
    // C17-C21: memory stalls
    tick(); redirect_valid = 1'b0; imem_req_ready = 1'b0; #1;
    chk("c17_inst_v", 32'(inst_valid), 32'h0);
    chk("c17_req_v", 32'(imem_req_valid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) begin tick(); #1; end
      chk("stall_pc_en", 32'(pc_enable_o), 32'h0);
      chk("stall_addr", imem_req_addr, 32'h100);
      chk("stall_pc_next", pc_next_o, 32'h100);
    end
    // C22: PC wrap
    tick(); imem_req_ready = 1'b1; use_force = 1'b1; pc_force = 32'hFFFF_FFFC; #1;
    chk("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
    chk("wrap_pc_en", 32'(pc_enable_o), 32'h1);
    chk("wrap_pc_next", pc_next_o, 32'h0);
    // C23: response for 0xFFFFFFFC queued
    tick(); use_force = 1'b0; inst_ready = 1'b0; #1;
    // C24: entry queued, issue request for 0 and hold its response
    tick(); mem_auto = 1'b0; #1;
    chk("c24_inst_pc", inst_pc, 32'hFFFF_FFFC);
    chk("c24_inst_d", inst_data, 32'h0000_0003);
    chk("c24_addr", imem_req_addr, 32'h0);
    // C25, C26: reset mid-operation
    tick(); rst = 1'b1; #1;
    tick(); #1;
    chk("mrst_pc_en", 32'(pc_enable_o), 32'h0);
    chk("mrst_req_v", 32'(imem_req_valid), 32'h0);
    chk("mrst_inst_v", 32'(inst_valid), 32'h0);
    chk("mrst_pc_next", pc_next_o, 32'h0);
    chk("mrst_inst_d", inst_data, 32'h0);
    // C27: late response after reset is ignored
    tick(); rst = 1'b0; imem_req_ready = 1'b0; man_rsp_valid = 1'b1; man_rsp_data = 32'h1234_5678; #1;
    chk("late_inst_v", 32'(inst_valid), 32'h0);
    tick(); man_rsp_valid = 1'b0; #1;
    chk("post_inst_v", 32'(inst_valid), 32'h0);
    chk("post_req_v", 32'(imem_req_valid), 32'h1);
    chk("post_addr", imem_req_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that drives the PC register and supplies the decoder.
- Takes the current PC from the PC register and issues one instruction-memory request at a time.
- Returns the next PC and its write enable to the PC register.
- Buffers returned instructions, each tagged with its PC, in a small queue toward decode; branch/jump redirects flush the queue and discard any stale memory response.

Parameters:
QDEPTH, 2, instruction queue entries (power of two, >=2)
XLEN, 32, address/data width

Ports:
clk  input  1  clock; all state updates on posedge clk
rst  input  1  synchronous, active-high reset; sampled on posedge clk
pc_in  input  XLEN  current PC from the PC register
pc_next_o  output  XLEN  next PC to the PC register
pc_enable_o  output  1  PC register write enable
imem_req_valid  output  1  request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  request address = {pc_in[XLEN-1:2],2'b00}
imem_rsp_valid  input  1  response valid, one per accepted request, >=1 cycle after accept
imem_rsp_data  input  XLEN  instruction word
redirect_valid  input  1  branch/jump taken from execute
redirect_pc  input  XLEN  target PC
inst_valid  output  1  queue head valid
inst_ready  input  1  decode consumes head
inst_data  output  XLEN  head instruction
inst_pc  output  XLEN  PC of head instruction

Behaviour:
- Reset: state IDLE, queue empty, count 0, all outputs 0 (pc_enable_o=0, imem_req_valid=0, inst_valid=0).
- Reset mid-operation: a pending response arriving after rst deasserts is ignored; it is not counted as outstanding.
- FSM states:
  - IDLE: no outstanding request.
  - WAIT: one request outstanding; its response is kept.
  - DROP: one request outstanding; its response is discarded.
- Request issue: imem_req_valid = (state==IDLE) && (count<QDEPTH) && !redirect_valid.
  - Handshake when imem_req_valid && imem_req_ready.
  - On handshake: IDLE->WAIT, latch addr into req_pc, pc_enable_o=1, pc_next_o=pc_in+4 (mod 2^XLEN, wrap 0xFFFFFFFC->0).
- WAIT with imem_rsp_valid:
  - Push {rsp_data, req_pc} into the queue, go to IDLE.
  - Space is guaranteed because a request was only issued with count<QDEPTH.
- Redirect (redirect_valid=1), any state, highest priority:
  - pc_enable_o=1, pc_next_o={redirect_pc[XLEN-1:2],2'b00}; queue flushed (count=0).
  - IDLE->IDLE, no request issued this cycle.
  - WAIT->DROP; if imem_rsp_valid arrives the same cycle, discard it and go to IDLE.
  - DROP->DROP, or IDLE if imem_rsp_valid arrives that cycle.
- DROP with imem_rsp_valid (no redirect): discard the data, go to IDLE.
- No request is issued while in WAIT or DROP.
- pc_enable_o=0 and pc_next_o=pc_in in all other cycles.
- Queue:
  - Circular buffer with rd/wr pointers of log2(QDEPTH) bits (wrap naturally) and count of log2(QDEPTH)+1 bits.
  - inst_valid=(count!=0); head fields are driven from the rd pointer.
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Flush overrides any same-cycle push or pop.
- Latency with 1-cycle memory:
  - Redirect at N -> request at N+1 -> response at N+2 -> inst_valid at N+3.
  - Steady state: one instruction per 2 cycles (single outstanding request).

Optional Feature:
FETCH_BYPASS_EN
- Defined: when count==0 and the response is kept, the response drives inst_valid, inst_data and inst_pc combinationally in the same cycle.
  - If inst_ready=1 that cycle, the instruction is not pushed.
  - Redirect in the same cycle still suppresses it.
- Undefined: responses always go through the queue; inst_valid never depends combinationally on imem_rsp_valid.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {IDLE, WAIT, DROP}
  - XLEN default
  - PC_STEP=4
  - RESET_PC=0
  - NOP=32'h0000_0013
- Sub-module fetch_queue (parameter QDEPTH; push/pop/flush; head data and PC; count) instantiated once.
- FSM and PC logic live in if_fetch_unit.

Test Plan:
- Reset then ready memory (1-cycle rsp), pc_in follows pc_next_o from 0 -> requests 0x0,0x4,0x8; inst_pc 0x0,0x4,0x8 in order with matching data.
- inst_ready=0 with QDEPTH=2 -> exactly 2 entries fill; imem_req_valid stays 0 until one pop; no entry lost.
- Redirect to 0x100 while WAIT (rsp for 0x8 two cycles later) -> rsp discarded, queue empty, next request addr 0x100, first inst_pc 0x100.
- Redirect in the same cycle as imem_rsp_valid in WAIT -> data not pushed, state IDLE, next req 0x100; redirect_pc 0x102 -> req addr 0x100.
- imem_req_ready held 0 for 5 cycles -> pc_enable_o=0 and addr stable throughout; pc_in=0xFFFFFFFC accepted -> pc_next_o=0x0.
- rst asserted with an entry queued and a request outstanding -> next cycle all outputs 0; a late imem_rsp_valid is ignored.
